sram_mem_stage: RTL and testbench

SRAM_MEM_STAGE -- requirements
Module: sram_mem_stage

---
 rtl/sram_mem_stage_pkg.sv | 14 +
 rtl/sram_mem_stage_wait_counter.sv | 29 ++
 rtl/sram_mem_stage.sv | 113 +++++++++++
 tb/tb_sram_mem_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_mem_stage_pkg.sv
// Shared pipeline definitions for the SRAM memory stage.
// FSM encoding and access-latency defaults live here.
package sram_mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int WAIT_CYCLES_DEF = 5;
    localparam int CNT_W = 4;

endpackage

// File: rtl/sram_mem_stage_wait_counter.sv
// Down-counter timing one SRAM access.
// Loads a start value, counts down, flags zero.
import sram_mem_stage_pkg::*;

module wait_counter (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load wins over decrement; decrement saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sram_mem_stage.sv
// Memory stage driving an asynchronous SRAM.
// Freezes the pipeline for the fixed access latency.
import sram_mem_stage_pkg::*;

module sram_mem_stage #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [31:0] alu_res,
    input  logic [31:0] val_rm,
    output logic        ready,
    output logic [31:0] mem_result,
    output logic [16:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        sram_we_n,
    output logic        sram_oe_n
);

    localparam logic [31:0] BASE = 32'(BASE_ADDR);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

    state_t state;
    state_t next_state;

    logic        req;
    logic        start;
    logic        last;
    logic        cnt_zero;
    logic [31:0] addr_off;
    logic        unused_addr_bits;

    assign req      = mem_read_in | mem_write_in;
    assign start    = (state == IDLE) && req;
    assign last     = (state == ACCESS) && cnt_zero;
    assign addr_off = alu_res - BASE;

    // Only word bits [18:2] reach the SRAM.
    assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

    wait_counter u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (start),
        .load_val (LOAD_VAL),
        .dec      (state == ACCESS),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and pipeline stall.
    always_comb begin
        next_state = state;
        ready      = 1'b1;
        unique case (state)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                ready = 1'b0;
                if (cnt_zero) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                ready      = 1'b1;
                next_state = IDLE;
            end
            default: begin
                ready      = 1'b1;
                next_state = IDLE;
            end
        endcase
    end

    // SRAM drivers and load capture; a store takes priority over a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            mem_result <= '0;
        end else if (start) begin
            sram_addr  <= addr_off[18:2];
            sram_wdata <= val_rm;
            sram_we_n  <= ~mem_write_in;
            sram_oe_n  <= mem_write_in;
        end else if (last) begin
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            if (!sram_oe_n) begin
                mem_result <= sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_mem_stage.sv
// Directed bench for sram_mem_stage.
// Runs a 5-cycle and a 1-cycle latency instance.
module tb_sram_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd5 = 1'b0;
    logic        wr5 = 1'b0;
    logic        rd1 = 1'b0;
    logic        wr1 = 1'b0;
    logic [31:0] alu_res = '0;
    logic [31:0] val_rm = '0;
    logic [31:0] sram_rdata = '0;

    logic        ready5, ready1;
    logic [31:0] res5, res1;
    logic [16:0] addr5, addr1;
    logic [31:0] wd5, wd1;
    logic        we5, we1, oe5, oe1;

    int total = 0;
    int bad = 0;
    int sel = 0;

    int low_cnt, we_cnt, oe_cnt, both_cnt;
    logic [16:0] cap_addr;
    logic [31:0] cap_wd;

    always #5 clk = ~clk;

    sram_mem_stage #(.BASE_ADDR(1024), .WAIT_CYCLES(5)) dut5 (
        .clk          (clk),
        .rst          (rst),
        .mem_read_in  (rd5),
        .mem_write_in (wr5),
        .alu_res      (alu_res),
        .val_rm       (val_rm),
        .ready        (ready5),
        .mem_result   (res5),
        .sram_addr    (addr5),
        .sram_wdata   (wd5),
        .sram_rdata   (sram_rdata),
        .sram_we_n    (we5),
        .sram_oe_n    (oe5)
    );

    sram_mem_stage #(.BASE_ADDR(1024), .WAIT_CYCLES(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .mem_read_in  (rd1),
        .mem_write_in (wr1),
        .alu_res      (alu_res),
        .val_rm       (val_rm),
        .ready        (ready1),
        .mem_result   (res1),
        .sram_addr    (addr1),
        .sram_wdata   (wd1),
        .sram_rdata   (sram_rdata),
        .sram_we_n    (we1),
        .sram_oe_n    (oe1)
    );

    logic        s_rdy, s_we, s_oe;
    logic [16:0] s_addr;
    logic [31:0] s_wd;
    assign s_rdy  = sel ? ready1 : ready5;
    assign s_we   = sel ? we1 : we5;
    assign s_oe   = sel ? oe1 : oe5;
    assign s_addr = sel ? addr1 : addr5;
    assign s_wd   = sel ? wd1 : wd5;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the request until ready rises; tally stall and enable cycles.
    task automatic measure();
        int n;
        low_cnt  = 0;
        we_cnt   = 0;
        oe_cnt   = 0;
        both_cnt = 0;
        cap_addr = '0;
        cap_wd   = '0;
        for (n = 0; n < 40; n++) begin
            #0;
            if (s_rdy) break;
            low_cnt++;
            if (!s_we) we_cnt++;
            if (!s_oe) oe_cnt++;
            if (!s_we && !s_oe) both_cnt++;
            if (!s_we || !s_oe) begin
                cap_addr = s_addr;
                cap_wd   = s_wd;
            end
            tick();
        end
        if (n >= 40) chk("timeout", n, 0);
        chk("done_en", {30'd0, s_we, s_oe}, 32'd3);
    endtask

    initial begin
        rst = 1'b1;
        #12;
        chk("rst_ready", {31'd0, ready5}, 32'd1);
        chk("rst_res", res5, 32'd0);
        chk("rst_we", {31'd0, we5}, 32'd1);
        chk("rst_oe", {31'd0, oe5}, 32'd1);
        chk("rst_addr", {15'd0, addr5}, 32'd0);
        chk("rst_wd", wd5, 32'd0);
        rst = 1'b0;
        tick();

        // Load at word 1.
        alu_res    = 32'd1028;
        sram_rdata = 32'hDEADBEEF;
        rd5        = 1'b1;
        #1;
        chk("ld_req_ready", {31'd0, ready5}, 32'd0);
        measure();
        chk("ld_low", low_cnt, 6);
        chk("ld_oe", oe_cnt, 5);
        chk("ld_we", we_cnt, 0);
        chk("ld_addr", {15'd0, cap_addr}, 32'd1);
        chk("ld_res", res5, 32'hDEADBEEF);

        // Store follows in the cycle after DONE.
        rd5        = 1'b0;
        wr5        = 1'b1;
        alu_res    = 32'd1024;
        val_rm     = 32'h12345678;
        sram_rdata = 32'h0;
        tick();
        chk("st_accept", {31'd0, ready5}, 32'd0);
        measure();
        chk("st_low", low_cnt, 6);
        chk("st_we", we_cnt, 5);
        chk("st_oe", oe_cnt, 0);
        chk("st_both", both_cnt, 0);
        chk("st_addr", {15'd0, cap_addr}, 32'd0);
        chk("st_wd", cap_wd, 32'h12345678);
        chk("st_res", res5, 32'hDEADBEEF);
        wr5 = 1'b0;
        tick();
        chk("idle_ready", {31'd0, ready5}, 32'd1);

        // Both requests: store only.
        rd5        = 1'b1;
        wr5        = 1'b1;
        alu_res    = 32'd1032;
        val_rm     = 32'hCAFEF00D;
        sram_rdata = 32'h11111111;
        measure();
        chk("both_we", we_cnt, 5);
        chk("both_oe", oe_cnt, 0);
        chk("both_addr", {15'd0, cap_addr}, 32'd2);
        chk("both_wd", cap_wd, 32'hCAFEF00D);
        chk("both_res", res5, 32'hDEADBEEF);
        rd5 = 1'b0;
        wr5 = 1'b0;
        tick();

        // Reset in the third ACCESS cycle of a load.
        rd5        = 1'b1;
        alu_res    = 32'd1028;
        sram_rdata = 32'hA5A5A5A5;
        tick();
        tick();
        tick();
        chk("pre_rst_oe", {31'd0, oe5}, 32'd0);
        rst = 1'b1;
        #1;
        chk("arst_oe", {31'd0, oe5}, 32'd1);
        chk("arst_we", {31'd0, we5}, 32'd1);
        chk("arst_res", res5, 32'd0);
        chk("arst_req", {31'd0, ready5}, 32'd0);
        rd5 = 1'b0;
        #1;
        chk("arst_ready", {31'd0, ready5}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("post_ready", {31'd0, ready5}, 32'd1);
        chk("post_oe", {31'd0, oe5}, 32'd1);
        chk("post_res", res5, 32'd0);

        // Single-cycle latency instance.
        sel        = 1;
        rd1        = 1'b1;
        alu_res    = 32'd1028;
        sram_rdata = 32'h0BADF00D;
        measure();
        chk("w1_low", low_cnt, 2);
        chk("w1_oe", oe_cnt, 1);
        chk("w1_res", res1, 32'h0BADF00D);
        rd1 = 1'b0;
        tick();

        // Address below base wraps modulo 2^32.
        wr1     = 1'b1;
        alu_res = 32'd1020;
        measure();
        chk("w1_wrap_addr", {15'd0, cap_addr}, 32'h1FFFF);
        chk("w1_wrap_we", we_cnt, 1);
        chk("w1_wrap_res", res1, 32'h0BADF00D);
        wr1 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
